// File: rtl/cluster_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cluster_scan_ctrl
//  Function : Label-propagation sequencer that groups points into clusters by
//             Manhattan distance over a point memory with dual read ports.
//  Revision : 1.0
// ============================================================================
module cluster_scan_ctrl #(
    parameter int N        = 16,
    parameter int MAX_PASS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] eps,
    output logic [3:0] raddr_i,
    output logic [3:0] raddr_j,
    input  logic [7:0] xi,
    input  logic [7:0] yi,
    input  logic [7:0] zi,
    input  logic [7:0] xj,
    input  logic [7:0] yj,
    input  logic [7:0] zj,
    input  logic [3:0] li,
    input  logic [3:0] lj,
    output logic       we,
    output logic [3:0] waddr,
    output logic [3:0] wlabel,
    output logic       busy,
    output logic       done,
    output logic       converged,
    output logic [3:0] pass_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] c_LAST     = 4'(N - 1);
    localparam logic [3:0] c_LAST_I   = 4'(N - 2);
    localparam logic [3:0] c_MAX_PASS = 4'(MAX_PASS);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [3:0] r_k;
    logic [3:0] r_i;
    logic [3:0] r_j;
    logic [9:0] r_eps;
    logic       r_changed;
    logic [3:0] r_pass_cnt;
    logic       r_converged;

    logic [7:0] w_dx;
    logic [7:0] w_dy;
    logic [7:0] w_dz;
    logic [9:0] w_dist;
    logic       w_merge;
    logic       w_last_pair;
    logic       w_more;

    assign w_dx   = (xi >= xj) ? (xi - xj) : (xj - xi);
    assign w_dy   = (yi >= yj) ? (yi - yj) : (yj - yi);
    assign w_dz   = (zi >= zj) ? (zi - zj) : (zj - zi);
    assign w_dist = {2'b00, w_dx} + {2'b00, w_dy} + {2'b00, w_dz};

    assign w_merge     = (w_dist <= r_eps) && (li != lj);
    assign w_last_pair = (r_i == c_LAST_I) && (r_j == c_LAST);
    assign w_more      = r_changed && (r_pass_cnt < c_MAX_PASS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_INIT;
            S_INIT:  if (r_k == c_LAST) w_next = S_SCAN;
            S_SCAN:  if (w_last_pair) w_next = S_CHECK;
            S_CHECK: w_next = w_more ? S_SCAN : S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k         <= 4'd0;
            r_i         <= 4'd0;
            r_j         <= 4'd0;
            r_eps       <= 10'd0;
            r_changed   <= 1'b0;
            r_pass_cnt  <= 4'd0;
            r_converged <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_eps       <= eps;
                        r_pass_cnt  <= 4'd0;
                        r_converged <= 1'b0;
                        r_k         <= 4'd0;
                    end
                end
                S_INIT: begin
                    r_k <= r_k + 4'd1;
                    if (r_k == c_LAST) begin
                        r_i        <= 4'd0;
                        r_j        <= 4'd1;
                        r_changed  <= 1'b0;
                        r_pass_cnt <= 4'd1;
                    end
                end
                S_SCAN: begin
                    if (w_merge) begin
                        r_changed <= 1'b1;
                    end
                    // Hold the final pair so the read addresses stay in range during CHECK.
                    if (!w_last_pair) begin
                        if (r_j == c_LAST) begin
                            r_i <= r_i + 4'd1;
                            r_j <= r_i + 4'd2;
                        end else begin
                            r_j <= r_j + 4'd1;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_more) begin
                        r_pass_cnt <= r_pass_cnt + 4'd1;
                        r_changed  <= 1'b0;
                        r_i        <= 4'd0;
                        r_j        <= 4'd1;
                    end else begin
                        r_converged <= ~r_changed;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        we     = 1'b0;
        waddr  = 4'd0;
        wlabel = 4'd0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_INIT: begin
                busy   = 1'b1;
                we     = 1'b1;
                waddr  = r_k;
                wlabel = r_k;
            end
            S_SCAN: begin
                busy = 1'b1;
                if (w_merge) begin
                    we = 1'b1;
                    // The larger label is overwritten so labels only ever decrease.
                    if (li < lj) begin
                        waddr  = r_j;
                        wlabel = li;
                    end else begin
                        waddr  = r_i;
                        wlabel = lj;
                    end
                end
            end
            S_CHECK: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
            end
        endcase
    end

    assign raddr_i   = r_i;
    assign raddr_j   = r_j;
    assign pass_cnt  = r_pass_cnt;
    assign converged = r_converged;

endmodule
`default_nettype wire

// File: tb/tb_cluster_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cluster_scan_ctrl
//  Function : Scoreboard bench with point-memory models for two controllers.
//  Revision : 1.0
// ============================================================================
module tb_cluster_scan_ctrl;

    typedef struct {
        longint      t0;
        logic [3:0]  pc;
        logic        cv;
        logic [63:0] labs;
        int          lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [9:0] eps0, eps1;
    logic [3:0] raddr_i0, raddr_j0, raddr_i1, raddr_j1;
    logic [7:0] xi0, yi0, zi0, xj0, yj0, zj0;
    logic [7:0] xi1, yi1, zi1, xj1, yj1, zj1;
    logic [3:0] li0, lj0, li1, lj1;
    logic       we0, we1, busy0, busy1, done0, done1, conv0, conv1;
    logic [3:0] waddr0, waddr1, wlabel0, wlabel1, pc0, pc1;

    logic [7:0] px [16];
    logic [7:0] py [16];
    logic [7:0] pz [16];
    logic [3:0] lab0 [16];
    logic [3:0] lab1 [16];

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;
    exp_t   q0 [$];
    exp_t   q1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cluster_scan_ctrl #(.N(16), .MAX_PASS(15)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .eps(eps0),
        .raddr_i(raddr_i0), .raddr_j(raddr_j0),
        .xi(xi0), .yi(yi0), .zi(zi0), .xj(xj0), .yj(yj0), .zj(zj0),
        .li(li0), .lj(lj0), .we(we0), .waddr(waddr0), .wlabel(wlabel0),
        .busy(busy0), .done(done0), .converged(conv0), .pass_cnt(pc0)
    );

    cluster_scan_ctrl #(.N(16), .MAX_PASS(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .eps(eps1),
        .raddr_i(raddr_i1), .raddr_j(raddr_j1),
        .xi(xi1), .yi(yi1), .zi(zi1), .xj(xj1), .yj(yj1), .zj(zj1),
        .li(li1), .lj(lj1), .we(we1), .waddr(waddr1), .wlabel(wlabel1),
        .busy(busy1), .done(done1), .converged(conv1), .pass_cnt(pc1)
    );

    assign xi0 = px[raddr_i0];  assign yi0 = py[raddr_i0];  assign zi0 = pz[raddr_i0];
    assign xj0 = px[raddr_j0];  assign yj0 = py[raddr_j0];  assign zj0 = pz[raddr_j0];
    assign xi1 = px[raddr_i1];  assign yi1 = py[raddr_i1];  assign zi1 = pz[raddr_i1];
    assign xj1 = px[raddr_j1];  assign yj1 = py[raddr_j1];  assign zj1 = pz[raddr_j1];
    assign li0 = lab0[raddr_i0];
    assign lj0 = lab0[raddr_j0];
    assign li1 = lab1[raddr_i1];
    assign lj1 = lab1[raddr_j1];

    always @(posedge clk) begin
        if (we0) lab0[waddr0] <= wlabel0;
        if (we1) lab1[waddr1] <= wlabel1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: on each done pulse, pop the oldest expectation and compare.
    always @(negedge clk) begin
        exp_t        e;
        logic [63:0] act;
        if (done0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_unexpected_done: got 1 expected 0");
            end else begin
                e = q0.pop_front();
                for (int k = 0; k < 16; k++) act[4*k +: 4] = lab0[k];
                chk("dut0_pass_cnt", 64'(pc0), 64'(e.pc));
                chk("dut0_converged", 64'(conv0), 64'(e.cv));
                chk("dut0_latency", 64'(cyc - e.t0), 64'(e.lat));
                chk("dut0_labels", act, e.labs);
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_done: got 1 expected 0");
            end else begin
                e = q1.pop_front();
                for (int k = 0; k < 16; k++) act[4*k +: 4] = lab1[k];
                chk("dut1_pass_cnt", 64'(pc1), 64'(e.pc));
                chk("dut1_converged", 64'(conv1), 64'(e.cv));
                chk("dut1_latency", 64'(cyc - e.t0), 64'(e.lat));
                chk("dut1_labels", act, e.labs);
            end
        end
    end

    // 0: all at (7,7,7); 1: x=16k on a line; 2: threshold pair; 3: multi-pass chain
    task automatic set_pts(input int pat);
        for (int k = 0; k < 16; k++) begin
            px[k] = 8'(16 * k);
            py[k] = (pat == 1) ? 8'd0 : 8'd255;
            pz[k] = 8'd0;
            if (pat == 0) begin
                px[k] = 8'd7;
                py[k] = 8'd7;
                pz[k] = 8'd7;
            end
        end
        if (pat == 2) begin
            px[0] = 8'd0;  py[0] = 8'd0;  pz[0] = 8'd0;
            px[1] = 8'd3;  py[1] = 8'd4;  pz[1] = 8'd3;
        end
        if (pat == 3) begin
            px[0] = 8'd0;   py[0] = 8'd0;
            px[2] = 8'd10;  py[2] = 8'd0;
            px[3] = 8'd20;  py[3] = 8'd0;
            px[1] = 8'd30;  py[1] = 8'd0;
        end
    endtask

    function automatic logic [63:0] ident();
        logic [63:0] v;
        for (int k = 0; k < 16; k++) v[4*k +: 4] = 4'(k);
        return v;
    endfunction

    // pulse_at / rst_at: cycle after the accepting edge (1 = first INIT cycle).
    task automatic run(input int inst, input logic [9:0] e, input logic [3:0] pc,
                       input logic cv, input logic [63:0] labs, input int lat,
                       input int pulse_at, input int rst_at);
        exp_t x;
        int   n;
        @(negedge clk);
        x.t0 = cyc; x.pc = pc; x.cv = cv; x.labs = labs; x.lat = lat;
        if (rst_at == 0) begin
            if (inst == 0) q0.push_back(x); else q1.push_back(x);
        end
        if (inst == 0) begin start0 = 1'b1; eps0 = e; end
        else           begin start1 = 1'b1; eps1 = e; end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        if (pulse_at > 0) begin
            repeat (pulse_at - 1) @(negedge clk);
            start0 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
        end
        if (rst_at > 0) begin
            repeat (rst_at - 1) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            chk("abort_busy", 64'(busy0), 64'd0);
            chk("abort_we", 64'(we0), 64'd0);
            chk("abort_done", 64'(done0), 64'd0);
            rst = 1'b0;
            return;
        end
        n = 0;
        while (((inst == 0) ? done0 : done1) !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 1000 cycles");
        end
    endtask

    initial begin
        logic [63:0] thr, mp;
        int          n;
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        eps0 = 10'd0;  eps1 = 10'd0;
        set_pts(0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_we", 64'(we0), 64'd0);
        chk("rst_converged", 64'(conv0), 64'd0);
        chk("rst_pass_cnt", 64'(pc0), 64'd0);
        chk("rst_raddr_i", 64'(raddr_i0), 64'd0);
        chk("rst_raddr_j", 64'(raddr_j0), 64'd0);
        rst = 1'b0;

        thr = ident();
        thr[7:4] = 4'd0;
        mp = ident();
        mp[15:4] = 12'd0;

        set_pts(0); run(0, 10'd0,  4'd2, 1'b1, 64'd0,   259, 0, 0);
        set_pts(1); run(0, 10'd15, 4'd1, 1'b1, ident(), 138, 0, 0);
        set_pts(2); run(0, 10'd10, 4'd2, 1'b1, thr,     259, 0, 0);
                    run(0, 10'd9,  4'd1, 1'b1, ident(), 138, 0, 0);
        set_pts(3); run(0, 10'd10, 4'd3, 1'b1, mp,      380, 0, 0);
                    run(1, 10'd10, 4'd2, 1'b0, mp,      259, 0, 0);
        // Second start in the 5th SCAN cycle must be ignored.
        run(0, 10'd10, 4'd3, 1'b1, mp, 380, 21, 0);
        // Reset in the 20th SCAN cycle, then a clean rerun.
        run(0, 10'd10, 4'd0, 1'b0, 64'd0, 0, 0, 36);
        run(0, 10'd10, 4'd3, 1'b1, mp, 380, 0, 0);
        // Back-to-back: all-zero labels, then a run that must restore identity.
        set_pts(1); run(0, 10'd16, 4'd2, 1'b1, 64'd0,   259, 0, 0);
                    run(0, 10'd15, 4'd1, 1'b1, ident(), 138, 0, 0);

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q0.size() + q1.size());
        end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
